// File: rtl/mul_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mul_unit
//  Description : Iterative shift-add multiplier for the multicycle ARM core.
//                Executes MUL, MLA, UMULL and SMULL, retiring BITS_PER_CYCLE
//                multiplier bits per CALC cycle, and returns registered
//                32/64-bit results with N/Z flags and a one-cycle done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module mul_unit #(
    parameter int BITS_PER_CYCLE = 1        // legal values: 1, 2, 4
) (
    input  logic        clk,
    input  logic        reset,              // asynchronous, active-low
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] acc,
    output logic        busy,
    output logic        done,
    output logic [31:0] result_lo,
    output logic [31:0] result_hi,
    output logic        flag_n,
    output logic        flag_z
);

    localparam int         c_N_INT    = 32 / BITS_PER_CYCLE;
    localparam logic [5:0] c_N        = 6'(c_N_INT);

    localparam logic [1:0] c_OP_MUL   = 2'b00;
    localparam logic [1:0] c_OP_MLA   = 2'b01;
    localparam logic [1:0] c_OP_UMULL = 2'b10;
    localparam logic [1:0] c_OP_SMULL = 2'b11;

    localparam logic [1:0] c_S_IDLE   = 2'd0;
    localparam logic [1:0] c_S_CALC   = 2'd1;
    localparam logic [1:0] c_S_FINISH = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  w_next_state;
    logic        w_load;
    logic        w_step;
    logic        w_finish;

    logic [1:0]  r_op;
    logic [63:0] r_mcand;       // multiplicand, pre-shifted to the current bit offset
    logic [31:0] r_mplier;      // remaining multiplier bits, consumed from the LSB end
    logic [31:0] r_acc;
    logic        r_sign;
    logic [63:0] r_prod;
    logic [5:0]  r_cnt;
    logic        r_done;

    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [63:0] w_addend;
    logic [63:0] w_res;
    logic [31:0] w_fin_lo;
    logic [31:0] w_fin_hi;
    logic        w_fin_n;
    logic        w_fin_z;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; the counter value 1 marks the last CALC edge
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_S_IDLE:   if (start) w_next_state = c_S_CALC;
            c_S_CALC:   if (r_cnt == 6'd1) w_next_state = c_S_FINISH;
            c_S_FINISH: w_next_state = c_S_IDLE;
            default:    w_next_state = c_S_IDLE;
        endcase
    end

    // State decode driving the datapath enables
    always_comb begin
        w_load   = 1'b0;
        w_step   = 1'b0;
        w_finish = 1'b0;
        case (r_state)
            c_S_IDLE:   w_load   = start;
            c_S_CALC:   w_step   = 1'b1;
            c_S_FINISH: w_finish = 1'b1;
            default:    ;
        endcase
    end

    // SMULL works on magnitudes; 0x80000000 negates to itself and is read unsigned
    assign w_abs_a = a[31] ? (~a + 32'd1) : a;
    assign w_abs_b = b[31] ? (~b + 32'd1) : b;

    // Partial product for this cycle: multiplicand times the low multiplier bits
    always_comb begin
        w_addend = 64'd0;
        for (int j = 0; j < BITS_PER_CYCLE; j++) begin
            if (r_mplier[j]) begin
                w_addend = w_addend + (r_mcand << j);
            end
        end
    end

    // Operand capture and iterative accumulation
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_op     <= 2'd0;
            r_mcand  <= 64'd0;
            r_mplier <= 32'd0;
            r_acc    <= 32'd0;
            r_sign   <= 1'b0;
            r_prod   <= 64'd0;
            r_cnt    <= 6'd0;
        end else if (w_load) begin
            r_op   <= op;
            r_acc  <= acc;
            r_prod <= 64'd0;
            r_cnt  <= c_N;
            if (op == c_OP_SMULL) begin
                r_mcand  <= {32'd0, w_abs_a};
                r_mplier <= w_abs_b;
                r_sign   <= a[31] ^ b[31];
            end else begin
                r_mcand  <= {32'd0, a};
                r_mplier <= b;
                r_sign   <= 1'b0;
            end
        end else if (w_step) begin
            r_prod   <= r_prod + w_addend;
            r_mcand  <= r_mcand << BITS_PER_CYCLE;
            r_mplier <= r_mplier >> BITS_PER_CYCLE;
            r_cnt    <= r_cnt - 6'd1;
        end
    end

    // Final result formatting and flags from the completed partial product
    always_comb begin
        w_res = r_prod;
        case (r_op)
            c_OP_MUL:   w_res = {32'd0, r_prod[31:0]};
            c_OP_MLA:   w_res = {32'd0, r_prod[31:0] + r_acc};
            c_OP_UMULL: w_res = r_prod;
            c_OP_SMULL: w_res = r_sign ? (~r_prod + 64'd1) : r_prod;
            default:    w_res = r_prod;
        endcase
        w_fin_lo = w_res[31:0];
        w_fin_hi = w_res[63:32];
        w_fin_n  = r_op[1] ? w_fin_hi[31] : w_fin_lo[31];
        w_fin_z  = r_op[1] ? (w_res == 64'd0) : (w_fin_lo == 32'd0);
    end

    // Output registers, written only on the FINISH edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            result_lo <= 32'd0;
            result_hi <= 32'd0;
            flag_n    <= 1'b0;
            flag_z    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= w_finish;
            if (w_finish) begin
                result_lo <= w_fin_lo;
                result_hi <= w_fin_hi;
                flag_n    <= w_fin_n;
                flag_z    <= w_fin_z;
            end
        end
    end

    assign busy = (r_state != c_S_IDLE);
    assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_mul_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mul_unit
//  Description : Scoreboard bench for mul_unit: directed and random operations
//                on a BITS_PER_CYCLE=1 unit, plus latency/result checks of
//                BITS_PER_CYCLE=2 and 4 instances.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_unit;

    localparam int c_N1 = 32;

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        logic        n;
        logic        z;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, start2, start4;
    logic [1:0]  op;
    logic [31:0] a, b, acc;

    logic        busy, done, flag_n, flag_z;
    logic [31:0] result_lo, result_hi;
    logic        busy2, done2, flag_n2, flag_z2;
    logic [31:0] result_lo2, result_hi2;
    logic        busy4, done4, flag_n4, flag_z4;
    logic [31:0] result_lo4, result_hi4;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   ndone = 0;
    int   seen2 = 0;
    int   seen4 = 0;
    int   exp2_cyc = 0;
    int   exp4_cyc = 0;
    exp_t q[$];
    exp_t e_umull;

    mul_unit #(.BITS_PER_CYCLE(1)) u_dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b), .acc(acc),
        .busy(busy), .done(done), .result_lo(result_lo), .result_hi(result_hi),
        .flag_n(flag_n), .flag_z(flag_z)
    );

    mul_unit #(.BITS_PER_CYCLE(2)) u_dut2 (
        .clk(clk), .reset(reset), .start(start2), .op(op), .a(a), .b(b), .acc(acc),
        .busy(busy2), .done(done2), .result_lo(result_lo2), .result_hi(result_hi2),
        .flag_n(flag_n2), .flag_z(flag_z2)
    );

    mul_unit #(.BITS_PER_CYCLE(4)) u_dut4 (
        .clk(clk), .reset(reset), .start(start4), .op(op), .a(a), .b(b), .acc(acc),
        .busy(busy4), .done(done4), .result_lo(result_lo4), .result_hi(result_hi4),
        .flag_n(flag_n4), .flag_z(flag_z4)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: plain arithmetic on the architectural definition
    function automatic exp_t model(input logic [1:0] mop, input logic [31:0] ma,
                                   input logic [31:0] mb, input logic [31:0] macc);
        exp_t        e;
        logic [63:0] r;
        case (mop)
            2'b00:   r = {32'd0, 32'(ma * mb)};
            2'b01:   r = {32'd0, 32'(ma * mb + macc)};
            2'b10:   r = {32'd0, ma} * {32'd0, mb};
            default: r = 64'($signed({{32{ma[31]}}, ma}) * $signed({{32{mb[31]}}, mb}));
        endcase
        e.lo  = r[31:0];
        e.hi  = r[63:32];
        e.n   = mop[1] ? r[63] : r[31];
        e.z   = (r == 64'd0);
        e.cyc = 0;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    function automatic logic [31:0] rnd32();
        case ($urandom_range(0, 6))
            0:       return 32'h0000_0000;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    // Scoreboard monitor for the main unit
    always @(negedge clk) begin
        if (reset) begin
            if (busy && done) chk("busy_and_done", 1'b1, 1'b0);
            if (done) begin
                ndone++;
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: got done=1 expected no pending op (cycle %0d)", cyc);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("result_lo", result_lo, e.lo);
                    chk("result_hi", result_hi, e.hi);
                    chk("flag_n", flag_n, e.n);
                    chk("flag_z", flag_z, e.z);
                    chk("done_cycle", cyc, e.cyc);
                end
            end
        end
    end

    // Monitors for the wider-radix instances (single UMULL each)
    always @(negedge clk) begin
        if (reset && done2) begin
            seen2++;
            chk("bpc2_lo", result_lo2, e_umull.lo);
            chk("bpc2_hi", result_hi2, e_umull.hi);
            chk("bpc2_n", flag_n2, e_umull.n);
            chk("bpc2_z", flag_z2, e_umull.z);
            chk("bpc2_done_cycle", cyc, exp2_cyc);
        end
        if (reset && done4) begin
            seen4++;
            chk("bpc4_lo", result_lo4, e_umull.lo);
            chk("bpc4_hi", result_hi4, e_umull.hi);
            chk("bpc4_n", flag_n4, e_umull.n);
            chk("bpc4_z", flag_z4, e_umull.z);
            chk("bpc4_done_cycle", cyc, exp4_cyc);
        end
    end

    // Start one operation on the main unit; called and returns at a negedge
    task automatic issue(input logic [1:0] iop, input logic [31:0] ia, input logic [31:0] ib,
                         input logic [31:0] iacc, input bit push);
        int   w;
        exp_t e;
        w = 0;
        while (busy && w < 200) begin
            @(negedge clk);
            w++;
        end
        chk("idle_wait", busy, 1'b0);
        op    = iop;
        a     = ia;
        b     = ib;
        acc   = iacc;
        start = 1'b1;
        if (push) begin
            e     = model(iop, ia, ib, iacc);
            e.cyc = cyc + c_N1 + 2;
            q.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
        op    = 2'($urandom);
        a     = $urandom;
        b     = $urandom;
        acc   = $urandom;
    endtask

    task automatic wait_done();
        int w;
        w = 0;
        while (!done && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk("done_wait", done, 1'b1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, got no end expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int nd;
        reset  = 1'b0;
        start  = 1'b0;
        start2 = 1'b0;
        start4 = 1'b0;
        op     = 2'd0;
        a      = 32'd0;
        b      = 32'd0;
        acc    = 32'd0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_lo", result_lo, 32'd0);
        chk("rst_hi", result_hi, 32'd0);
        chk("rst_n", flag_n, 1'b0);
        chk("rst_z", flag_z, 1'b0);
        reset = 1'b1;
        @(negedge clk);

        // MLA 3*4+5 with busy duration
        issue(2'b01, 32'd3, 32'd4, 32'd5, 1'b1);
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("mla_busy_cycles", n, 33);

        // MUL wrap to zero
        issue(2'b00, 32'h0001_0000, 32'h0001_0000, 32'd0, 1'b1);

        // UMULL on all three radices at once
        n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        op       = 2'b10;
        a        = 32'hFFFF_FFFF;
        b        = 32'hFFFF_FFFF;
        e_umull  = model(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0);
        exp2_cyc = cyc + 16 + 2;
        exp4_cyc = cyc + 8 + 2;
        start2   = 1'b1;
        start4   = 1'b1;
        issue(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b1);
        start2   = 1'b0;
        start4   = 1'b0;

        // SMULL sign cases
        issue(2'b11, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1);
        issue(2'b11, 32'h8000_0000, 32'h8000_0000, 32'd0, 1'b1);
        issue(2'b11, 32'd0, 32'h8000_0000, 32'd0, 1'b1);

        // start pulsed mid-CALC with other operands must be ignored
        issue(2'b11, 32'hFFFF_FF85, 32'h0000_1234, 32'd9, 1'b1);
        repeat (5) @(negedge clk);
        op    = 2'b01;
        a     = 32'h1111_1111;
        b     = 32'h2222_2222;
        acc   = 32'h3333_3333;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;

        // Back-to-back: start sampled in the done cycle
        issue(2'b10, $urandom, $urandom, 32'd0, 1'b1);
        wait_done();
        issue(2'b00, $urandom, $urandom, 32'd0, 1'b1);

        // Randomized traffic with random idle gaps
        for (int i = 0; i < 25; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                wait_done();
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
            issue(2'($urandom_range(0, 3)), rnd32(), rnd32(), rnd32(), 1'b1);
        end

        // Make outputs nonzero, then abort an operation with reset
        issue(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b1);
        wait_done();
        @(negedge clk);
        issue(2'b01, 32'h1234_5678, 32'h9ABC_DEF0, 32'h55, 1'b0);
        repeat (9) @(negedge clk);
        nd    = ndone;
        reset = 1'b0;
        #1;
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        chk("abort_lo", result_lo, 32'd0);
        chk("abort_hi", result_hi, 32'd0);
        chk("abort_n", flag_n, 1'b0);
        chk("abort_z", flag_z, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (40) @(negedge clk);
        chk("no_done_after_abort", ndone, nd);
        chk("idle_after_abort", busy, 1'b0);

        // Fresh operation after reset release
        issue(2'b00, 32'd7, 32'd6, 32'd0, 1'b1);

        // Drain scoreboard
        n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk("scoreboard_empty", q.size(), 0);
        chk("bpc2_done_count", seen2, 1);
        chk("bpc4_done_count", seen4, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
